dcb_cfg_avmm_mem: RTL and testbench

//  Avalon-MM slave memory serving the avmm_0_rw master of the DCB config-copy kernel (main).

---
 rtl/dcb_cfg_avmm_mem.sv | 138 +++++++++++++
 tb/tb_dcb_cfg_avmm_mem.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dcb_cfg_avmm_mem.sv
// Avalon-MM config-table memory for the DCB config-copy kernel: self-clearing, fixed read latency, byte-enabled writes.
// Define DCB_CFG_MEM_CHANGE_CNT_EN to build the data-changing-write counter behind change_count.
module dcb_cfg_avmm_mem #(
  parameter int DEPTH        = 64,
  parameter int READ_LATENCY = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [63:0]       avmm_0_rw_address,
  input  logic [7:0]        avmm_0_rw_byteenable,
  input  logic              avmm_0_rw_read,
  output logic [63:0]       avmm_0_rw_readdata,
  input  logic              avmm_0_rw_write,
  input  logic [63:0]       avmm_0_rw_writedata,
  output logic              init_busy,
  output logic              oob_err,
  output logic [CNT_W-1:0]  change_count,
  input  logic              host_clr
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
  localparam logic [0:0]      ST_CLEAR = 1'b0;
  localparam logic [0:0]      ST_IDLE  = 1'b1;

  function automatic logic [63:0] byte_mask(input logic [7:0] be);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  logic [0:0]      state;
  logic [AW-1:0]   clr_ptr;
  logic [63:0]     mem [DEPTH];
  logic [AW-1:0]   idx;
  logic            in_range;
  logic            idle;
  logic            wr_ok;
  logic            oob_evt;
  logic [63:0]     old_word;
  logic [63:0]     rd_word;
  logic [63:0]     wr_mask;
  logic            tail_vld;
  logic [63:0]     tail_data;
  logic            unused_addr_lsb;

  // Byte offset within the 64-bit word carries no information.
  assign unused_addr_lsb = &{1'b0, avmm_0_rw_address[2:0]};

  assign idx       = avmm_0_rw_address[AW+2:3];
  assign in_range  = (avmm_0_rw_address[63:AW+3] == '0);
  assign idle      = (state == ST_IDLE);
  assign init_busy = (state == ST_CLEAR);
  assign old_word  = mem[idx];
  assign rd_word   = (idle && in_range) ? old_word : '0;
  assign wr_mask   = byte_mask(avmm_0_rw_byteenable);
  assign wr_ok     = avmm_0_rw_write && idle && in_range;
  assign oob_evt   = (avmm_0_rw_read || avmm_0_rw_write) && !(idle && in_range);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_ptr <= clr_ptr + AW'(1);
      if (clr_ptr == LAST_IDX) state <= ST_IDLE;
    end
  end

  // Storage: the clear sweep owns the write port until it reaches IDLE.
  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) mem[clr_ptr] <= '0;
    else if (wr_ok)        mem[idx]     <= (old_word & ~wr_mask) | (avmm_0_rw_writedata & wr_mask);
  end

  // Read stage p0: word sampled at accept, shifted through READ_LATENCY-1 registers.
  if (READ_LATENCY == 1) begin : g_lat1
    assign tail_vld  = avmm_0_rw_read;
    assign tail_data = rd_word;
  end else begin : g_latn
    logic [READ_LATENCY-2:0] rd_vld_p;
    logic [63:0]             rd_data_p [READ_LATENCY-1];

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        rd_vld_p <= '0;
      end else begin
        rd_vld_p[0] <= avmm_0_rw_read;
        for (int k = 1; k < READ_LATENCY - 1; k++) rd_vld_p[k] <= rd_vld_p[k-1];
      end
    end

    always_ff @(posedge clock) begin
      rd_data_p[0] <= rd_word;
      for (int k = 1; k < READ_LATENCY - 1; k++) rd_data_p[k] <= rd_data_p[k-1];
    end

    assign tail_vld  = rd_vld_p[READ_LATENCY-2];
    assign tail_data = rd_data_p[READ_LATENCY-2];
  end

  // Output stage: readdata holds until the next read result lands.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)       avmm_0_rw_readdata <= '0;
    else if (tail_vld) avmm_0_rw_readdata <= tail_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)       oob_err <= 1'b0;
    else if (oob_evt)  oob_err <= 1'b1;
    else if (host_clr) oob_err <= 1'b0;
  end

`ifdef DCB_CFG_MEM_CHANGE_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             changed;
  logic [CNT_W-1:0] cnt_q;

  // Only enabled bytes take part in the compare against the stored word.
  assign changed = |((old_word ^ avmm_0_rw_writedata) & wr_mask);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                cnt_q <= '0;
    else if (host_clr)          cnt_q <= '0;
    else if (wr_ok && changed)  cnt_q <= sat_inc(cnt_q);
  end

  assign change_count = cnt_q;
`else
  assign change_count = '0;
`endif

endmodule

// File: tb/tb_dcb_cfg_avmm_mem.sv
// Directed self-checking bench for dcb_cfg_avmm_mem (DEPTH=64, READ_LATENCY=2).
module tb_dcb_cfg_avmm_mem;

  localparam int DEPTH = 64;
  localparam int RL    = 2;
  localparam int CNT_W = 16;
`ifdef DCB_CFG_MEM_CHANGE_CNT_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif

  logic              clock = 1'b0;
  logic              resetn;
  logic [63:0]       address;
  logic [7:0]        byteenable;
  logic              read;
  logic [63:0]       readdata;
  logic              write;
  logic [63:0]       writedata;
  logic              init_busy;
  logic              oob_err;
  logic [CNT_W-1:0]  change_count;
  logic              host_clr;

  int n_cmp  = 0;
  int n_fail = 0;

  dcb_cfg_avmm_mem #(.DEPTH(DEPTH), .READ_LATENCY(RL), .CNT_W(CNT_W)) dut (
    .clock                (clock),
    .resetn               (resetn),
    .avmm_0_rw_address    (address),
    .avmm_0_rw_byteenable (byteenable),
    .avmm_0_rw_read       (read),
    .avmm_0_rw_readdata   (readdata),
    .avmm_0_rw_write      (write),
    .avmm_0_rw_writedata  (writedata),
    .init_busy            (init_busy),
    .oob_err              (oob_err),
    .change_count         (change_count),
    .host_clr             (host_clr)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] cnt_exp(input int v);
    return (CE != 0) ? 64'(v) : 64'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    tick();
    write = 1'b0; byteenable = 8'h00;
  endtask

  task automatic rd_check(input string tag, input logic [63:0] a, input logic [63:0] exp);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    tick();
    check(tag, readdata, exp);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (init_busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    resetn = 1'b0; address = '0; byteenable = '0; read = 1'b0;
    write = 1'b0; writedata = '0; host_clr = 1'b0;
    repeat (3) tick();
    check("rst_init_busy", 64'(init_busy), 64'd1);
    check("rst_readdata", readdata, 64'd0);
    check("rst_oob", 64'(oob_err), 64'd0);
    check("rst_count", 64'(change_count), 64'd0);

    // Release reset and write during the clear sweep.
    resetn = 1'b1;
    wr(64'h8, 64'hDEAD_BEEF_0000_1234, 8'hFF);
    check("init_wr_oob", 64'(oob_err), 64'd1);
    wait_init(n);
    check("init_cycles", 64'(n + 1), 64'd64);
    check("init_done", 64'(init_busy), 64'd0);
    rd_check("init_wr_dropped", 64'h8, 64'd0);
    host_clr = 1'b1; tick(); host_clr = 1'b0;
    check("clr_oob0", 64'(oob_err), 64'd0);

    // Back-to-back sweep of every word.
    for (int i = 0; i < 66; i++) begin
      if (i < DEPTH) begin
        read = 1'b1; address = 64'(i * 8);
      end else begin
        read = 1'b0;
      end
      tick();
      if (i >= 2) check("sweep_zero", readdata, 64'd0);
    end
    check("sweep_oob", 64'(oob_err), 64'd0);

    wr(64'h10, 64'h1122334455667788, 8'hFF);
    check("cnt_full_wr", 64'(change_count), cnt_exp(1));
    address = 64'h10; read = 1'b1;
    tick();
    read = 1'b0;
    check("lat_not_early", readdata, 64'd0);
    tick();
    check("lat_exact", readdata, 64'h1122334455667788);
    tick();
    check("readdata_hold", readdata, 64'h1122334455667788);

    wr(64'h10, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    rd_check("be_low_half", 64'h10, 64'h11223344BBBBBBBB);
    check("cnt_be_wr", 64'(change_count), cnt_exp(2));
    wr(64'h10, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    check("cnt_same_wr", 64'(change_count), cnt_exp(2));
    wr(64'h14, 64'hFFFFFFFFBBBBBBBB, 8'h0F);
    check("cnt_masked_diff", 64'(change_count), cnt_exp(2));
    wr(64'h10, 64'h0, 8'h00);
    check("cnt_be_zero", 64'(change_count), cnt_exp(2));
    rd_check("be_zero_noop", 64'h10, 64'h11223344BBBBBBBB);

    // Out-of-range accesses.
    rd_check("oob_rd_data", 64'h200, 64'd0);
    check("oob_rd_flag", 64'(oob_err), 64'd1);
    wr(64'h8000_0000_0000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    rd_check("oob_hi_wr_dropped", 64'h10, 64'h11223344BBBBBBBB);
    check("oob_hi_cnt", 64'(change_count), cnt_exp(2));
    host_clr = 1'b1; tick(); host_clr = 1'b0;
    check("hclr_oob", 64'(oob_err), 64'd0);
    check("hclr_cnt", 64'(change_count), 64'd0);
    rd_check("oob_hi_rd", 64'h1_0000_0010, 64'd0);
    check("oob_hi_flag", 64'(oob_err), 64'd1);

    // host_clr races.
    host_clr = 1'b1;
    wr(64'h10, 64'h0102030405060708, 8'hFF);
    host_clr = 1'b0;
    check("clr_beats_cnt", 64'(change_count), 64'd0);
    check("clr_oob_only", 64'(oob_err), 64'd0);
    host_clr = 1'b1; read = 1'b1; address = 64'h200;
    tick();
    host_clr = 1'b0; read = 1'b0;
    check("set_beats_clr", 64'(oob_err), 64'd1);
    host_clr = 1'b1; tick(); host_clr = 1'b0;

    // Read-before-write on a shared cycle.
    wr(64'h18, 64'd5, 8'hFF);
    address = 64'h18; writedata = 64'd9; byteenable = 8'hFF; read = 1'b1; write = 1'b1;
    tick();
    read = 1'b0; write = 1'b0;
    tick();
    check("rbw_old", readdata, 64'd5);
    rd_check("rbw_new", 64'h18, 64'd9);
    check("cnt_after_rbw", 64'(change_count), cnt_exp(2));
    check("rbw_no_oob", 64'(oob_err), 64'd0);

    // One result per cycle.
    read = 1'b1; address = 64'h10;
    tick();
    address = 64'h18;
    tick();
    check("b2b_0", readdata, 64'h0102030405060708);
    address = 64'h10;
    tick();
    check("b2b_1", readdata, 64'd9);
    read = 1'b0;
    tick();
    check("b2b_2", readdata, 64'h0102030405060708);

    // Reset with a read in flight.
    read = 1'b1; address = 64'h18;
    tick();
    read = 1'b0;
    resetn = 1'b0;
    #1;
    check("midrst_readdata", readdata, 64'd0);
    check("midrst_busy", 64'(init_busy), 64'd1);
    tick();
    tick();
    resetn = 1'b1;
    wait_init(n);
    check("midrst_init_cycles", 64'(n), 64'd64);
    check("midrst_discard", readdata, 64'd0);
    check("midrst_cnt", 64'(change_count), 64'd0);
    check("midrst_oob", 64'(oob_err), 64'd0);
    rd_check("midrst_cleared", 64'h10, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
